myproject_mul_share_arb: RTL and testbench

MYPROJECT_MUL_SHARE_ARB -- requirements
Module: myproject_mul_share_arb

---
 rtl/myproject_mul_share_pkg.sv | 14 +
 rtl/myproject_mul_10ns_8s_18_1_1.sv | 32 +++
 rtl/myproject_mul_share_arb.sv | 114 +++++++++++
 tb/tb_myproject_mul_share_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mul_share_pkg.sv
// Shared definitions for the shared-multiplier arbiter.
// Holds the default requester count, operand/product widths, the
// requester-index width and the requester-index type.
package myproject_mul_share_pkg;

  localparam int NREQ_DEF = 4;    // requesters sharing one multiplier
  localparam int A_W_DEF  = 10;   // unsigned operand A width
  localparam int B_W_DEF  = 8;    // signed operand B width
  localparam int P_W_DEF  = 18;   // signed product width
  localparam int ID_W_DEF = $clog2(NREQ_DEF);

  typedef logic [ID_W_DEF-1:0] req_idx_t;

endpackage

// File: rtl/myproject_mul_10ns_8s_18_1_1.sv
// Combinational multiplier: unsigned din0 times signed din1, product
// truncated to DOUT_W bits.
// Ports:
//   din0 - unsigned operand (DIN0_W bits)
//   din1 - signed operand (DIN1_W bits)
//   dout - signed product (DOUT_W bits)
module myproject_mul_10ns_8s_18_1_1 #(
  parameter int DIN0_W = 10,
  parameter int DIN1_W = 8,
  parameter int DOUT_W = 18
) (
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic [DOUT_W-1:0] dout
);

  // Full-precision width: din0 gains a zero sign bit, then the sum of widths.
  localparam int FULL_W = DIN0_W + 1 + DIN1_W;

  logic signed [FULL_W-1:0] a_ext_s;
  logic signed [FULL_W-1:0] b_ext_s;
  logic signed [FULL_W-1:0] full_s;

  // Extend both operands to the full width so the multiply is exact, then truncate.
  always_comb begin
    a_ext_s = signed'({{(FULL_W-DIN0_W){1'b0}}, din0});
    b_ext_s = signed'({{(FULL_W-DIN1_W){din1[DIN1_W-1]}}, din1});
    full_s  = a_ext_s * b_ext_s;
    dout    = full_s[DOUT_W-1:0];
  end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters, with a
// single-entry result register (1-cycle latency, 1 product/cycle throughput).
// Ports:
//   ap_clk, ap_rst_n - clock, synchronous active-low reset
//   req_valid/ready  - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b     - packed per-requester operands (A unsigned, B signed)
//   rsp_valid/ready  - result handshake
//   rsp_id, rsp_p    - owning requester index and signed product
module myproject_mul_share_arb
  import myproject_mul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int A_W  = A_W_DEF,
  parameter int B_W  = B_W_DEF,
  parameter int P_W  = P_W_DEF
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*A_W-1:0]        req_a,
  input  logic [NREQ*B_W-1:0]        req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [P_W-1:0]             rsp_p
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] grant_idx_s;
  logic [ID_W-1:0] ptr_nxt_s;
  logic [ID_W:0]   cand_s;
  logic            found_s;
  logic            slot_free_s;
  logic            accept_s;
  logic [A_W-1:0]  a_mux_s;
  logic [B_W-1:0]  b_mux_s;
  logic [P_W-1:0]  prod_s;

  // Round-robin search starting at ptr_r; the extra cand_s bit absorbs the wrap.
  always_comb begin
    grant_idx_s = '0;
    found_s     = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(NREQ)) begin
        cand_s = cand_s - (ID_W+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_valid[cand_s[ID_W-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s[ID_W-1:0];
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Accept when a requester is valid and the result slot is free or draining;
  // reset gates the accept so nothing is granted while ap_rst_n is low.
  always_comb begin
    slot_free_s = !rsp_valid || rsp_ready;
    accept_s    = found_s && slot_free_s && ap_rst_n;
    if (accept_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = '0;
    end
    if (grant_idx_s == ID_W'(NREQ-1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_idx_s + ID_W'(1);
    end
  end

  // Operand mux feeding the shared multiplier from the granted requester.
  always_comb begin
    a_mux_s = req_a[int'(grant_idx_s)*A_W +: A_W];
    b_mux_s = req_b[int'(grant_idx_s)*B_W +: B_W];
  end

  myproject_mul_10ns_8s_18_1_1 #(
    .DIN0_W (A_W),
    .DIN1_W (B_W),
    .DOUT_W (P_W)
  ) u_mul (
    .din0 (a_mux_s),
    .din1 (b_mux_s),
    .dout (prod_s)
  );

  // Result register and round-robin pointer; a drain and a new accept in the
  // same cycle reload the register so rsp_valid stays high.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      ptr_r     <= '0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_p     <= prod_s;
      rsp_id    <= grant_idx_s;
      ptr_r     <= ptr_nxt_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Self-checking bench for myproject_mul_share_arb: directed vector table,
// hand-written reset/round-robin sequences and a randomized scoreboard.
module tb_myproject_mul_share_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_ready;
  logic [39:0] req_a = 40'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [17:0] rsp_p;

  int checks = 0;
  int errors = 0;

  myproject_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mulx(input logic [9:0] a, input logic [7:0] b);
    int av;
    int bv;
    av = int'(a);
    bv = int'($signed(b));
    return av * bv;
  endfunction

  typedef struct {
    logic [3:0] valid;
    logic       rr;
    logic [3:0] exp_ready;
    logic       exp_rv;
    logic [1:0] exp_id;
    int         exp_p;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    int         p;
  } exp_t;

  vec_t vecs[13];
  exp_t sbq[$];

  // Operands used by the directed parts:
  //   req0: a=5,    b=-3   -> -15
  //   req1: a=1023, b=127  -> 129921
  //   req2: a=1023, b=-128 -> -130944
  //   req3: a=100,  b=-1   -> -100
  localparam logic [39:0] FIX_A = {10'd100, 10'd1023, 10'd1023, 10'd5};
  localparam logic [31:0] FIX_B = {8'hFF, 8'h80, 8'h7F, 8'hFD};

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] vld;
    logic [9:0] ar[4];
    logic [7:0] br[4];
    logic [3:0] exp_rdy;
    logic       model_rv;
    int         ptr_m;
    int         g;
    exp_t       e;

    // Directed table, starting right after reset (ptr = 0).
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, -130944};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, -130944};
    vecs[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, -15};
    vecs[3]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 129921};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, -130944};
    vecs[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, -100};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, -100};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, -100};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, -100};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, -15};
    vecs[10] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd0, -15};
    vecs[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, -100};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, -100};

    req_a = FIX_A;
    req_b = FIX_B;

    // Reset values, and req_ready held low while reset is asserted.
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_p", $signed(rsp_p), 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge ap_clk);
    req_valid = 4'b0000;
    ap_rst_n  = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge ap_clk);
      req_valid = vecs[i].valid;
      rsp_ready = vecs[i].rr;
      #2;
      chk($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_ready);
      @(posedge ap_clk); #1;
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rv);
      chk($sformatf("vec%0d_rsp_id", i), rsp_id, vecs[i].exp_id);
      chk($sformatf("vec%0d_rsp_p", i), $signed(rsp_p), vecs[i].exp_p);
    end

    // Reset mid-operation: a pending result from requester 1 must vanish
    // and the pointer (2 before reset) must return to 0.
    @(negedge ap_clk);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #2;
    chk("mid_pre_ready", req_ready, 4'b0010);
    @(posedge ap_clk); #1;
    chk("mid_pre_rsp_valid", rsp_valid, 1);
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = 4'b1111;
    #2;
    chk("mid_rst_ready", req_ready, 0);
    @(posedge ap_clk); #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_p", $signed(rsp_p), 0);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    #2;
    chk("mid_no_stale", rsp_valid, 0);

    // All four valid continuously: grants 0,1,2,3,0,1 with no bubble.
    begin
      int order[6] = '{0, 1, 2, 3, 0, 1};
      int prods[4] = '{-15, 129921, -130944, -100};
      for (int i = 0; i < 6; i++) begin
        if (i != 0) begin
          @(negedge ap_clk);
          #2;
        end
        chk($sformatf("rr%0d_ready", i), req_ready, 4'b0001 << order[i]);
        @(posedge ap_clk); #1;
        chk($sformatf("rr%0d_rsp_valid", i), rsp_valid, 1);
        chk($sformatf("rr%0d_rsp_id", i), rsp_id, order[i]);
        chk($sformatf("rr%0d_rsp_p", i), $signed(rsp_p), prods[order[i]]);
      end
    end

    // Random stimulus against a scoreboard and an independent pointer model.
    do_reset();
    ptr_m = 0;
    vld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ar[i] = 10'd0;
      br[i] = 8'd0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge ap_clk);
      req_valid = vld;
      for (int i = 0; i < 4; i++) begin
        req_a[i*10 +: 10] = ar[i];
        req_b[i*8 +: 8]   = br[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #2;
      model_rv = (sbq.size() != 0);
      exp_rdy = 4'b0000;
      g = -1;
      if (!model_rv || rsp_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && vld[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        end
        if (g >= 0) exp_rdy = 4'b0001 << g;
      end
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, model_rv);
      if (model_rv && rsp_ready) begin
        e = sbq.pop_front();
        chk("rnd_rsp_id", rsp_id, e.id);
        chk("rnd_rsp_p", $signed(rsp_p), e.p);
      end
      if (g >= 0) begin
        e.id = 2'(g);
        e.p  = mulx(ar[g], br[g]);
        sbq.push_back(e);
        ptr_m = (g + 1) % 4;
      end
      @(posedge ap_clk); #1;
      // Requesters hold until accepted, then may present new operands.
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] || g == i) begin
          vld[i] = ($urandom_range(0, 1) == 1);
          ar[i]  = 10'($urandom);
          br[i]  = 8'($urandom);
        end
      end
    end
    // Drain the last outstanding result.
    @(negedge ap_clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #2;
    chk("drain_rsp_valid", rsp_valid, (sbq.size() != 0));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("drain_rsp_id", rsp_id, e.id);
      chk("drain_rsp_p", $signed(rsp_p), e.p);
    end
    @(posedge ap_clk); #1;
    chk("drain_empty", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
